// File: rtl/tdm_demux_1x8.sv
// Receiving end of a serial TDM link: collects one sample per enable strobe into
// a shadow frame and publishes all eight channels at once when channel 7 arrives.
module tdm_demux_1x8 #(
  parameter int DW  = 1,
  parameter int NCH = 8,
  parameter int CW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     din,
  input  logic              en,
  input  logic              sync,
  output logic [CW-1:0]     ch_sel,
  output logic [NCH*DW-1:0] y,
  output logic              frame_valid,
  output logic              sync_err
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  state_t                    state, state_n;
  logic [CW-1:0]             ch_n;
  // The last channel goes straight from din into y, so it needs no shadow slot.
  logic [(NCH-1)*DW-1:0]     shadow, shadow_n;
  logic [NCH*DW-1:0]         y_n;
  logic                      frame_valid_n;
  logic                      sync_err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ch_sel      <= '0;
      shadow      <= '0;
      y           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_n;
      ch_sel      <= ch_n;
      shadow      <= shadow_n;
      y           <= y_n;
      frame_valid <= frame_valid_n;
      sync_err    <= sync_err_n;
    end
  end

  always_comb begin
    state_n       = state;
    ch_n          = ch_sel;
    shadow_n      = shadow;
    y_n           = y;
    frame_valid_n = 1'b0;
    sync_err_n    = 1'b0;

    if (en) begin
      case (state)
        IDLE: begin
          if (sync) begin
            shadow_n[0 +: DW] = din;
            ch_n              = CW'(1);
            state_n           = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // A sync anywhere but channel 0 drops the partial frame and restarts.
            sync_err_n        = (ch_sel != '0);
            shadow_n[0 +: DW] = din;
            ch_n              = CW'(1);
          end else if (ch_sel == '0) begin
            sync_err_n = 1'b1;
            state_n    = IDLE;
          end else if (ch_sel == LAST_CH) begin
            y_n           = {din, shadow};
            frame_valid_n = 1'b1;
            ch_n          = '0;
          end else begin
            shadow_n[ch_sel*DW +: DW] = din;
            ch_n                      = ch_sel + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          ch_n    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Self-checking bench for tdm_demux_1x8: expected frames are queued as they are
// driven and popped when frame_valid reports a completed frame.
module tb_tdm_demux_1x8;

  logic       clk;
  logic       rst;
  logic [0:0] din;
  logic       en;
  logic       sync;
  logic [2:0] ch_sel;
  logic [7:0] y;
  logic       frame_valid;
  logic       sync_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_y;
  logic [7:0] hold_y;

  tdm_demux_1x8 #(.DW(1), .NCH(8), .CW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .en          (en),
    .sync        (sync),
    .ch_sel      (ch_sel),
    .y           (y),
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run still active at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one enabled sample; outputs are stable on return.
  task automatic drive(input logic d, input logic s);
    @(negedge clk);
    din  = d;
    sync = s;
    en   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    @(negedge clk);
    en   = 1'b0;
    din  = 1'($urandom);
    sync = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_expected(output logic [7:0] e, output logic ok);
    ok = (exp_q.size() != 0);
    e  = ok ? exp_q.pop_front() : 8'hxx;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      din  = 1'($urandom);
      en   = 1'($urandom);
      sync = 1'($urandom);
      @(posedge clk);
      #1;
      total++; if (y !== 8'h00) begin bad++; $display("[TB] FAIL reset_y: got %h want 00", y); end
      total++; if (ch_sel !== 3'd0) begin bad++; $display("[TB] FAIL reset_ch: got %0d want 0", ch_sel); end
      total++; if (frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_fv: got %b want 0", frame_valid); end
      total++; if (sync_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", sync_err); end
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'(i + 1), 1'b0);
      total++; if (ch_sel !== 3'd0) begin bad++; $display("[TB] FAIL idle_nosync_ch: got %0d want 0", ch_sel); end
      total++; if (sync_err !== 1'b0) begin bad++; $display("[TB] FAIL idle_nosync_err: got %b want 0", sync_err); end
    end
  endtask

  task automatic test_single_frame;
    logic [7:0] pat;
    logic ok;
    pat = 8'hAA;
    exp_q.push_back(pat);
    for (int k = 0; k < 8; k++) begin
      drive(pat[k], k == 0);
      total++; if (ch_sel !== 3'((k + 1) % 8)) begin bad++; $display("[TB] FAIL single_ch k=%0d: got %0d want %0d", k, ch_sel, (k + 1) % 8); end
      total++; if (sync_err !== 1'b0) begin bad++; $display("[TB] FAIL single_err k=%0d: got %b want 0", k, sync_err); end
      total++; if (frame_valid !== (k == 7)) begin bad++; $display("[TB] FAIL single_fv k=%0d: got %b want %b", k, frame_valid, k == 7); end
      if (frame_valid === 1'b1) begin
        pop_expected(exp_y, ok);
        total++; if (!ok || y !== exp_y) begin bad++; $display("[TB] FAIL single_y: got %h want %h", y, exp_y); end
      end
    end
    gap(1);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_fv_pulse: got %b want 0", frame_valid); end
    total++; if (y !== 8'hAA) begin bad++; $display("[TB] FAIL single_y_hold: got %h want aa", y); end
  endtask

  task automatic test_gapped_frames;
    logic [7:0] pats [2];
    logic ok;
    pats[0] = 8'h3C;
    pats[1] = 8'hC3;
    hold_y  = 8'hAA;
    exp_q.push_back(pats[0]);
    exp_q.push_back(pats[1]);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        drive(pats[f][k], k == 0);
        total++; if (sync_err !== 1'b0) begin bad++; $display("[TB] FAIL gapped_err f=%0d k=%0d: got %b want 0", f, k, sync_err); end
        total++; if (frame_valid !== (k == 7)) begin bad++; $display("[TB] FAIL gapped_fv f=%0d k=%0d: got %b want %b", f, k, frame_valid, k == 7); end
        if (frame_valid === 1'b1) begin
          pop_expected(exp_y, ok);
          total++; if (!ok || y !== exp_y) begin bad++; $display("[TB] FAIL gapped_y f=%0d: got %h want %h", f, y, exp_y); end
          hold_y = pats[f];
        end
        gap(2);
        total++; if (ch_sel !== 3'((k + 1) % 8)) begin bad++; $display("[TB] FAIL gapped_ch_hold f=%0d k=%0d: got %0d want %0d", f, k, ch_sel, (k + 1) % 8); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL gapped_fv_hold f=%0d k=%0d: got %b want 0", f, k, frame_valid); end
        total++; if (y !== hold_y) begin bad++; $display("[TB] FAIL gapped_y_hold f=%0d k=%0d: got %h want %h", f, k, y, hold_y); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pats [3];
    logic ok;
    pats[0] = 8'h96;
    pats[1] = 8'h69;
    pats[2] = 8'h81;
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(pats[f]);
      for (int k = 0; k < 8; k++) begin
        drive(pats[f][k], k == 0);
        total++; if (sync_err !== 1'b0) begin bad++; $display("[TB] FAIL b2b_err f=%0d k=%0d: got %b want 0", f, k, sync_err); end
        total++; if (frame_valid !== (k == 7)) begin bad++; $display("[TB] FAIL b2b_fv f=%0d k=%0d: got %b want %b", f, k, frame_valid, k == 7); end
        if (frame_valid === 1'b1) begin
          pop_expected(exp_y, ok);
          total++; if (!ok || y !== exp_y) begin bad++; $display("[TB] FAIL b2b_y f=%0d: got %h want %h", f, y, exp_y); end
        end
      end
    end
  endtask

  task automatic test_early_sync;
    logic [7:0] pat;
    logic ok;
    pat    = 8'h5A;
    hold_y = 8'h81;
    exp_q.push_back(pat);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k == 0);
      total++; if (sync_err !== 1'b0) begin bad++; $display("[TB] FAIL early_pre_err k=%0d: got %b want 0", k, sync_err); end
    end
    for (int k = 0; k < 8; k++) begin
      drive(pat[k], k == 0);
      total++; if (sync_err !== (k == 0)) begin bad++; $display("[TB] FAIL early_err k=%0d: got %b want %b", k, sync_err, k == 0); end
      total++; if (ch_sel !== 3'((k + 1) % 8)) begin bad++; $display("[TB] FAIL early_ch k=%0d: got %0d want %0d", k, ch_sel, (k + 1) % 8); end
      total++; if (frame_valid !== (k == 7)) begin bad++; $display("[TB] FAIL early_fv k=%0d: got %b want %b", k, frame_valid, k == 7); end
      if (k < 7) begin
        total++; if (y !== hold_y) begin bad++; $display("[TB] FAIL early_y_hold k=%0d: got %h want %h", k, y, hold_y); end
      end else begin
        pop_expected(exp_y, ok);
        total++; if (!ok || y !== exp_y) begin bad++; $display("[TB] FAIL early_y: got %h want %h", y, exp_y); end
      end
    end
  endtask

  task automatic test_missing_sync;
    logic [7:0] pat;
    logic ok;
    drive(1'b1, 1'b0);
    total++; if (sync_err !== 1'b1) begin bad++; $display("[TB] FAIL miss_err: got %b want 1", sync_err); end
    total++; if (ch_sel !== 3'd0) begin bad++; $display("[TB] FAIL miss_ch: got %0d want 0", ch_sel); end
    total++; if (y !== 8'h5A) begin bad++; $display("[TB] FAIL miss_y: got %h want 5a", y); end
    for (int i = 0; i < 3; i++) begin
      drive(1'(i), 1'b0);
      total++; if (sync_err !== 1'b0) begin bad++; $display("[TB] FAIL miss_idle_err i=%0d: got %b want 0", i, sync_err); end
      total++; if (ch_sel !== 3'd0) begin bad++; $display("[TB] FAIL miss_idle_ch i=%0d: got %0d want 0", i, ch_sel); end
    end
    pat = 8'hE7;
    exp_q.push_back(pat);
    for (int k = 0; k < 8; k++) begin
      drive(pat[k], k == 0);
      total++; if (sync_err !== 1'b0) begin bad++; $display("[TB] FAIL miss_restart_err k=%0d: got %b want 0", k, sync_err); end
      total++; if (ch_sel !== 3'((k + 1) % 8)) begin bad++; $display("[TB] FAIL miss_restart_ch k=%0d: got %0d want %0d", k, ch_sel, (k + 1) % 8); end
    end
    pop_expected(exp_y, ok);
    total++; if (frame_valid !== 1'b1 || !ok || y !== exp_y) begin bad++; $display("[TB] FAIL miss_restart_y: got fv=%b y=%h want fv=1 y=%h", frame_valid, y, exp_y); end
  endtask

  task automatic test_mid_reset;
    logic [7:0] pat;
    logic ok;
    pat = 8'hF0;
    for (int k = 0; k < 4; k++) drive(pat[k], k == 0);
    @(negedge clk);
    rst  = 1'b1;
    en   = 1'b1;
    sync = 1'b0;
    din  = 1'b1;
    @(posedge clk);
    #1;
    total++; if (y !== 8'h00) begin bad++; $display("[TB] FAIL midrst_y: got %h want 00", y); end
    total++; if (ch_sel !== 3'd0) begin bad++; $display("[TB] FAIL midrst_ch: got %0d want 0", ch_sel); end
    total++; if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin bad++; $display("[TB] FAIL midrst_pulses: got fv=%b err=%b want 0 0", frame_valid, sync_err); end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    pat = 8'h0F;
    exp_q.push_back(pat);
    for (int k = 0; k < 8; k++) begin
      drive(pat[k], k == 0);
      total++; if (frame_valid !== (k == 7)) begin bad++; $display("[TB] FAIL midrst_fv k=%0d: got %b want %b", k, frame_valid, k == 7); end
    end
    pop_expected(exp_y, ok);
    total++; if (!ok || y !== exp_y) begin bad++; $display("[TB] FAIL midrst_y_after: got %h want %h", y, exp_y); end
    gap(1);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    sync = 1'b0;
    din  = 1'b0;
    test_reset;
    test_single_frame;
    test_gapped_frames;
    test_back_to_back;
    test_early_sync;
    test_missing_sync;
    test_mid_reset;
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  always @(negedge clk) begin
    if (!rst && frame_valid === 1'b1 && sync_err === 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL pulse_exclusive: got fv=1 err=1 want not both");
    end
  end

endmodule
